// File: rtl/ram_pkg.sv
// ram_pkg: shared state type and depth helper for the synchronous data RAM
package ram_pkg;
  typedef enum logic {RAM_IDLE, RAM_CLEAR} ram_state_t;
  function automatic int ram_depth(input int size_log);
    return 1 << size_log;
  endfunction
endpackage

// File: rtl/ram_sync_if.sv
// ram_sync_if: request/response bus between address decode and the data RAM
interface ram_sync_if #(parameter int WORD = 1, parameter int SIZE_LOG = 8);
  logic                read;
  logic                write;
  logic                clear;
  logic [SIZE_LOG-1:0] address;
  logic [WORD-1:0]     data_in;
  logic [WORD-1:0]     write_mask;
  logic [WORD-1:0]     data_out;
  logic                rd_valid;
  logic                busy;
  modport master (output read, write, clear, address, data_in, write_mask, input data_out, rd_valid, busy);
  modport slave  (input read, write, clear, address, data_in, write_mask, output data_out, rd_valid, busy);
endinterface

// File: rtl/ram_sync_array.sv
// ram_sync_array: masked-write storage with a registered write-first read port
module ram_sync_array
  import ram_pkg::*;
#(
  parameter int WORD     = 1,
  parameter int SIZE_LOG = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic                re,
  input  logic [SIZE_LOG-1:0] waddr,
  input  logic [SIZE_LOG-1:0] raddr,
  input  logic [WORD-1:0]     wdata,
  input  logic [WORD-1:0]     wmask,
  output logic [WORD-1:0]     rdata
);
  localparam int DEPTH = ram_depth(SIZE_LOG);
  logic [WORD-1:0] mem [DEPTH];
  logic [WORD-1:0] merged;
  assign merged = (mem[waddr] & ~wmask) | (wdata & wmask);
  // storage has no reset; only the read register does
  always_ff @(posedge clk)
    if (we) mem[waddr] <= merged;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= (we && waddr == raddr) ? merged : mem[raddr];
endmodule

// File: rtl/ram_sync.sv
// ram_sync: clocked data RAM with masked writes, 1-cycle reads and a zero-clear sweep
module ram_sync
  import ram_pkg::*;
#(
  parameter int WORD          = 1,
  parameter int SIZE_LOG      = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic      clk,
  input logic      rst,
  ram_sync_if.slave bus
);
  ram_state_t state, state_n;
  logic [SIZE_LOG-1:0] cnt;
  logic idle, last, take, we, re;
  always_comb begin
    idle    = state == RAM_IDLE;
    last    = &cnt;
    take    = !rst && idle && !bus.clear;
    we      = (!rst && !idle) || (take && bus.write);
    re      = take && bus.read;
    state_n = idle ? (bus.clear ? RAM_CLEAR : RAM_IDLE) : (last ? RAM_IDLE : RAM_CLEAR);
  end
  // cnt sits at 0 whenever idle, so a new sweep always starts at address 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= INIT_ON_RESET ? RAM_CLEAR : RAM_IDLE;
      cnt          <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= (idle || last) ? '0 : cnt + 1'b1;
      bus.rd_valid <= re;
    end
  assign bus.busy = !idle;
  ram_sync_array #(.WORD(WORD), .SIZE_LOG(SIZE_LOG)) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .re    (re),
    .waddr (idle ? bus.address : cnt),
    .raddr (bus.address),
    .wdata (idle ? bus.data_in : {WORD{1'b0}}),
    .wmask (idle ? bus.write_mask : {WORD{1'b1}}),
    .rdata (bus.data_out)
  );
endmodule
